// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int SUM_W = 64;

  function automatic int acc_width(input int width, input int cols);
    return 2 * width + $clog2(cols) + 1;
  endfunction

  // Floor rescale by frac_bits, then clamp to the signed width-bit range.
  function automatic logic signed [SUM_W-1:0] sat_rescale(
    input  logic signed [SUM_W-1:0] sum,
    input  int                      width,
    input  int                      frac_bits,
    output logic                    sat
  );
    logic signed [SUM_W-1:0] shifted;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    shifted = sum >>> frac_bits;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (width - 1));
    sat     = 1'b0;
    if (shifted > hi) begin
      sat = 1'b1;
      return hi;
    end
    if (shifted < lo) begin
      sat = 1'b1;
      return lo;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/mvm_lane.sv
// One MAC lane: accumulates a*x over the columns, then bias/rescale/saturate/ReLU.
module mvm_lane
  import mvm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COLS      = 4,
  parameter int FRAC_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_load,
  input  logic             acc_en,
  input  logic             wb_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] bias,
  input  logic             relu_en,
  output logic [WIDTH-1:0] elem,
  output logic             sat
);

  localparam int ACC_W = acc_width(WIDTH, COLS);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [WIDTH-1:0]   bias_s;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   val;
  logic                      sat_raw;

  assign prod   = $signed(a) * $signed(x);
  assign bias_s = $signed(bias);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_load ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    sum     = SUM_W'(acc_q) + (SUM_W'(bias_s) <<< FRAC_BITS);
    sat_raw = 1'b0;
    val     = sat_rescale(sum, WIDTH, FRAC_BITS, sat_raw);
    // ReLU applies after saturation so a clamped negative still reports overflow.
    if (relu_en && (val < 0)) begin
      val = '0;
    end
    elem = val[WIDTH-1:0];
    sat  = wb_en & sat_raw;
  end

endmodule

// File: rtl/mvm_stream.sv
// Streaming matrix-vector multiplier: LANES MAC lanes time-multiplexed over ROWS/LANES passes.
module mvm_stream
  import mvm_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 4,
  parameter int LANES     = 2,
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*COLS*WIDTH-1:0] matrix,
  input  logic [COLS*WIDTH-1:0]      vector,
  input  logic [ROWS*WIDTH-1:0]      bias,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROWS*WIDTH-1:0]      result,
  output logic                       overflow,
  output logic                       busy
);

  localparam int PASSES = ROWS / LANES;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t state_q, state_d;

  logic [CW-1:0]              c_q;
  logic [PW-1:0]              p_q;
  logic [ROWS*COLS*WIDTH-1:0] mat_q;
  logic [COLS*WIDTH-1:0]      vec_q;
  logic [ROWS*WIDTH-1:0]      bias_q;
  logic                       relu_q;
  logic [ROWS*WIDTH-1:0]      result_q;
  logic                       overflow_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic c_last, p_last;
  logic accept, acc_en, acc_load, wb_en;

  logic [WIDTH-1:0] lane_a    [LANES];
  logic [WIDTH-1:0] lane_bias [LANES];
  logic [WIDTH-1:0] lane_elem [LANES];
  logic [WIDTH-1:0] lane_x;
  logic [LANES-1:0] lane_sat;

  assign c_last = (c_q == CW'(COLS - 1));
  assign p_last = (p_q == PW'(PASSES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (c_last) state_d = WB;
      WB:      state_d = p_last ? HOLD : MAC;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
    accept   = (state_q == IDLE) && in_valid;
    acc_en   = (state_q == MAC);
    acc_load = acc_en && (c_q == '0);
    wb_en    = (state_q == WB);
  end

  // Lane l of pass p works on row p*LANES+l; all lanes share the current vector element.
  always_comb begin
    lane_a    = '{default: '0};
    lane_bias = '{default: '0};
    lane_x    = vec_q[int'(c_q)*WIDTH +: WIDTH];
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_a[l]    = mat_q[((int'(p_q)*LANES + int'(l))*COLS + int'(c_q))*WIDTH +: WIDTH];
      lane_bias[l] = bias_q[(int'(p_q)*LANES + int'(l))*WIDTH +: WIDTH];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mvm_lane #(
      .WIDTH    (WIDTH),
      .COLS     (COLS),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .acc_load(acc_load),
      .acc_en  (acc_en),
      .wb_en   (wb_en),
      .a       (lane_a[g]),
      .x       (lane_x),
      .bias    (lane_bias[g]),
      .relu_en (relu_q),
      .elem    (lane_elem[g]),
      .sat     (lane_sat[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q         <= '0;
      p_q         <= '0;
      mat_q       <= '0;
      vec_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        mat_q      <= matrix;
        vec_q      <= vector;
        bias_q     <= bias;
        relu_q     <= relu_en;
        c_q        <= '0;
        p_q        <= '0;
        overflow_q <= 1'b0;
        busy_q     <= 1'b1;
      end
      if (acc_en) begin
        c_q <= c_last ? '0 : c_q + 1'b1;
      end
      if (wb_en) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          result_q[(int'(p_q)*LANES + int'(l))*WIDTH +: WIDTH] <= lane_elem[l];
        end
        overflow_q <= overflow_q | (|lane_sat);
        if (p_last) begin
          out_valid_q <= 1'b1;
        end else begin
          p_q <= p_q + 1'b1;
        end
      end
      if ((state_q == HOLD) && out_ready) begin
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mvm_stream.sv
// Directed bench for mvm_stream with ROWS=4, COLS=3, LANES=2, WIDTH=8, FRAC_BITS=4.
module tb_mvm_stream;

  localparam int ROWS      = 4;
  localparam int COLS      = 3;
  localparam int LANES     = 2;
  localparam int WIDTH     = 8;
  localparam int FRAC_BITS = 4;

  logic                       clk;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*COLS*WIDTH-1:0] matrix;
  logic [COLS*WIDTH-1:0]      vector;
  logic [ROWS*WIDTH-1:0]      bias;
  logic                       relu_en;
  logic                       out_valid;
  logic                       out_ready;
  logic [ROWS*WIDTH-1:0]      result;
  logic                       overflow;
  logic                       busy;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] held_result;
  logic        held_ovf;

  mvm_stream #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .LANES    (LANES),
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .matrix   (matrix),
    .vector   (vector),
    .bias     (bias),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input byte e0, input byte e1, input byte e2, input byte e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic set_row(input int r, input byte m0, input byte m1, input byte m2);
    matrix[(r*COLS+0)*WIDTH +: WIDTH] = m0;
    matrix[(r*COLS+1)*WIDTH +: WIDTH] = m1;
    matrix[(r*COLS+2)*WIDTH +: WIDTH] = m2;
  endtask

  task automatic set_all(input byte m, input byte v);
    for (int r = 0; r < ROWS; r++) set_row(r, m, m, m);
    vector = {v, v, v};
    bias   = '0;
  endtask

  task automatic set_basic();
    set_row(0, 16, 0, 0);
    set_row(1, 0, 16, 0);
    set_row(2, 0, 0, 16);
    set_row(3, 16, 16, 16);
    vector = {8'hF0, 8'd32, 8'd16};
    bias   = '0;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  // lat counts cycles after the accept edge (first negedge after accept is cycle 1).
  task automatic run_op(input string tag, input logic relu, output int cycles);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    relu_en  = relu;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, out_valid, 1'b0);
    chk({tag, "_hs_in_ready"}, in_ready, 1'b1);
    chk({tag, "_hs_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    relu_en   = 1'b0;
    matrix    = '0;
    vector    = '0;
    bias      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Basic product
    set_basic();
    run_op("basic", 1'b0, lat);
    chk("basic_latency", 64'(lat), 64'd9);
    chk("basic_result", result, pack4(16, 32, -16, 32));
    chk("basic_overflow", overflow, 1'b0);
    chk("basic_busy", busy, 1'b1);
    handshake("basic");

    // Bias with ReLU, then without
    bias = {8'd0, 8'd8, 8'd0, 8'd0};
    run_op("relu", 1'b1, lat);
    chk("relu_result", result, pack4(16, 32, 0, 32));
    chk("relu_overflow", overflow, 1'b0);
    handshake("relu");
    run_op("bias", 1'b0, lat);
    chk("bias_result", result, pack4(16, 32, -8, 32));
    handshake("bias");

    // Saturation, both directions, and ReLU after negative saturation
    set_all(127, 127);
    run_op("satpos", 1'b0, lat);
    chk("satpos_result", result, 32'h7F7F7F7F);
    chk("satpos_overflow", overflow, 1'b1);
    handshake("satpos");
    set_all(-128, 127);
    run_op("satneg", 1'b0, lat);
    chk("satneg_result", result, 32'h80808080);
    chk("satneg_overflow", overflow, 1'b1);
    handshake("satneg");
    run_op("satrelu", 1'b1, lat);
    chk("satrelu_result", result, 32'h0);
    chk("satrelu_overflow", overflow, 1'b1);
    handshake("satrelu");

    // Floor rescale; also shows overflow cleared by the new accept
    set_row(0, 1, 0, 0);
    set_row(1, -1, 0, 0);
    set_row(2, 0, 0, 0);
    set_row(3, -1, -1, -1);
    vector = {8'd1, 8'd1, 8'd1};
    bias   = '0;
    run_op("floor", 1'b0, lat);
    chk("floor_latency", 64'(lat), 64'd9);
    chk("floor_result", result, pack4(0, -1, 0, -1));
    chk("floor_overflow", overflow, 1'b0);

    // Backpressure: hold the result while new operands are offered
    held_result = result;
    held_ovf    = overflow;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      set_all(byte'(i + 3), 100);
      @(negedge clk);
      chk("bp_result", result, held_result);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_overflow", overflow, held_ovf);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake("bp");
    set_basic();
    run_op("after_bp", 1'b0, lat);
    chk("after_bp_latency", 64'(lat), 64'd9);
    chk("after_bp_result", result, pack4(16, 32, -16, 32));
    handshake("after_bp");

    // Reset in cycle T+3 of an operation, with a nonzero result still held
    set_all(127, 127);
    run_op("pre_rst", 1'b0, lat);
    chk("pre_rst_result", result, 32'h7F7F7F7F);
    handshake("pre_rst");
    set_basic();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("mid_rst_hold_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    run_op("post_rst", 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd9);
    chk("post_rst_result", result, pack4(16, 32, -16, 32));
    chk("post_rst_overflow", overflow, 1'b0);
    handshake("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_stream.md
# mvm_stream

Streaming, parametrised fixed-point matrix-vector multiplier with bias add, optional ReLU and saturation. It time-multiplexes `LANES` parallel MAC lanes over `ROWS/LANES` row passes. It sits between the layer sequencer and the activation buffer in the NN accelerator datapath. Operands are accepted and results are returned through valid/ready handshakes, so layers can be chained with backpressure.

## Interface
- `ROWS`, 8: matrix rows / result elements; must be a multiple of `LANES`
- `COLS`, 4: matrix columns / vector elements; ≥1
- `LANES`, 2: parallel MAC lanes
- `WIDTH`, 8: signed two's-complement element width (inputs, bias, result)
- `FRAC_BITS`, 4: fractional bits of every WIDTH-bit operand; < WIDTH
- Clocking: reset `reset`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock
- `reset`  in  1  async active-high reset
- `in_valid`  in  1  operand set valid
- `in_ready`  out  1  block can accept operands
- `matrix`  in  ROWS*COLS*WIDTH  element (r,c) at bits [(r*COLS+c)*WIDTH +: WIDTH]
- `vector`  in  COLS*WIDTH  element c at [c*WIDTH +: WIDTH]
- `bias`  in  ROWS*WIDTH  element r at [r*WIDTH +: WIDTH], same Q format
- `relu_en`  in  1  clamp negative results to 0
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  ROWS*WIDTH  element r at [r*WIDTH +: WIDTH]
- `overflow`  out  1  any element saturated in this result; qualified by out_valid
- `busy`  out  1  high from accept until output handshake

## Operation
- States: IDLE, MAC, WB, HOLD. `in_ready` = (state==IDLE) and not in reset.
- IDLE: on `in_valid && in_ready`, register `matrix`, `vector`, `bias` and `relu_en`; clear the pass counter `p`; go to MAC. Inputs are ignored at all other times.
- MAC: column counter `c` runs 0..COLS-1. Lane l accumulates matrix(p*LANES+l, c)*vector(c). Accumulators load (rather than add) when c==0. After c==COLS-1, go to WB.
- WB: each lane computes its result element (rules below) and writes it to `result[p*LANES+l]`. If p==ROWS/LANES-1, go to HOLD; otherwise increment p and return to MAC.
- HOLD: `out_valid`=1 and `result`/`overflow` are held stable. On `out_ready`, go to IDLE.
- Arithmetic:
  - The accumulator is signed, ACC_W = 2*WIDTH + clog2(COLS) + 1 bits, and never overflows.
  - sum = acc + (bias sign-extended, shifted left by FRAC_BITS).
  - Rescale by arithmetic shift right by FRAC_BITS (floor, no rounding).
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If relu_en, clamp negative values to 0 after saturation.
- `overflow` is cleared on accept and ORs in every saturation event of the operation. A ReLU clamp is not an overflow.
- `reset` asserted at any time: state goes to IDLE, counters and accumulators clear, and `result`=0, `out_valid`=0, `overflow`=0, `busy`=0. `in_ready` is 0 while reset is high and 1 in the first cycle after release. An in-flight operation is discarded.

## Timing
- Accept at edge T. MAC pass 0 occupies cycles T+1..T+COLS, WB pass 0 occurs at T+COLS+1, and so on for each pass.
- `out_valid` rises at T + (ROWS/LANES)*(COLS+1) + 1. Example: ROWS=4, COLS=3, LANES=2 gives 9 cycles.
- An output handshake at edge H puts the block in IDLE at H+1, so the earliest next accept is H+1. Operations do not overlap.
- Throughput is one operation per (ROWS/LANES)*(COLS+1) + 2 cycles with `out_ready` held high.
- All outputs are registered except `in_ready`, which is decoded from the state register.

## Structure
- Package `mvm_pkg` holds:
  - the state enum (IDLE, MAC, WB, HOLD)
  - the function `acc_width(WIDTH, COLS)`
  - the saturate-and-rescale function `sat_rescale(sum, WIDTH, FRAC_BITS)`
- Sub-module `mvm_lane`: one MAC accumulator plus the bias/rescale/saturate/ReLU post-process. It exposes `acc_load`, `acc_en` and `wb_en`, and outputs a WIDTH-bit element and a `sat` flag. The top level instantiates LANES copies and contains the FSM, counters and operand/result registers.

## Test plan
Configuration for all scenarios: ROWS=4, COLS=3, LANES=2, WIDTH=8, FRAC_BITS=4, where 16 represents 1.0.

- **Basic product:** matrix rows [16,0,0], [0,16,0], [0,0,16], [16,16,16]; vector [16,32,-16]; bias 0; relu_en=0 -> result [16,32,-16,32], overflow=0, `out_valid` exactly 9 cycles after accept.
- **Bias and ReLU:** same operands with bias [0,0,8,0] and relu_en=1 -> result [16,32,0,32]. With relu_en=0 -> [16,32,-8,32].
- **Saturation:**
  - All matrix elements 127, vector 127 -> every element 127, overflow=1.
  - Matrix -128, vector 127 -> every element -128, overflow=1.
- **Floor rescale:**
  - Row [1,0,0] · vector [1,...] gives 0.
  - Row [-1,0,0] · vector [1,...] gives -1.
- **Backpressure:**
  - Hold out_ready=0 for 20 cycles while pulsing in_valid: result, out_valid and overflow stay stable and in_ready=0.
  - Then assert out_ready: in_ready=1 the next cycle, and a new accept yields the correct result.
- **Reset mid-operation:** assert reset at cycle T+3 of an operation -> all outputs are 0 during reset. A subsequent basic-product operation returns [16,32,-16,32] with the correct latency.
